// File: rtl/dmem_pkg.sv
// Shared types for the data-memory request engine.
// Request/response bundles and the engine's run state.
package dmem_pkg;

    localparam int LSQ_ID_W = 4;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [31:0]         addr;
        logic [DATA_W-1:0]   data;
        logic                rw;
        logic [LSQ_ID_W-1:0] id;
    } dmem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [LSQ_ID_W-1:0] id;
    } dmem_resp_t;

    typedef enum logic {
        INIT,
        RUN
    } dmem_state_e;

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request buffer between the LSQ and the RAM pipeline.
// Pointers wrap naturally; count carries one extra bit for full.
module dmem_req_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  dmem_req_t     req_i,
    input  logic          pop_i,
    output dmem_req_t     head_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    dmem_req_t         mem_q [DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [PW:0]       cnt_q;

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= req_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_request_engine.sv
// LSQ-facing data-memory engine: request FIFO, RAM, fixed-latency return.
// Optional DMEM_INIT_CLEAR_EN zero-sweeps the RAM after reset.
module dmem_request_engine
    import dmem_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int LATENCY   = 2,
    parameter int ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    input  logic [3:0]  id_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic [3:0]  id_out,
    output logic        ready_out,
    output logic        stall_out,
    output logic        overflow_err
);

    localparam int CW = $clog2(REQ_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_AT = CW'(REQ_DEPTH - 1);
`ifdef DMEM_INIT_CLEAR_EN
    localparam logic STALL_RST = 1'b1;
`else
    localparam logic STALL_RST = 1'b0;
`endif

    dmem_state_e       state_q, state_d;
    dmem_req_t         req, head;
    logic [CW-1:0]     count, cnt_d;
    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_data;
    logic [31:0]       ram_q [2**ADDR_W];
    logic [LATENCY-1:0] pv_q;
    dmem_resp_t        pr_q [LATENCY];
    dmem_resp_t        out_q;
    logic              ready_q, stall_q, ovf_q;
    logic              unused_addr;

    assign req  = '{addr: addr_in, data: data_in, rw: rw_in, id: id_in};
    assign pop  = !empty;
    assign push = valid_in && (state_q == RUN) && (!full || pop);
    assign idx  = head.addr[ADDR_W+1:2];
    assign rd_data = ram_q[idx];
    assign unused_addr = ^{head.addr[31:ADDR_W+2], head.addr[1:0]};

    dmem_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .req_i   (req),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef DMEM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    // Run-state and sweep-position register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Walk every word once, then stay in RUN.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == '1) state_d = RUN;
            end
            RUN: ;
            default: state_d = INIT;
        endcase
    end

    // RAM port: sweep clears during INIT, stores commit at pop.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            ram_q[sweep_q] <= '0;
        end else if (pop && head.rw) begin
            ram_q[idx] <= head.data;
        end
    end
`else
    assign state_q = RUN;
    assign state_d = RUN;

    // RAM port: stores commit at pop; loads read the pre-edge value.
    always_ff @(posedge clk) begin
        if (pop && head.rw) begin
            ram_q[idx] <= head.data;
        end
    end
`endif

    // Occupancy after this edge's push/pop.
    always_comb begin
        cnt_d = count;
        if (push && !pop) cnt_d = count + 1'b1;
        else if (pop && !push) cnt_d = count - 1'b1;
    end

    // Fixed-latency return pipe, output hold, stall and overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q    <= '0;
            for (int i = 0; i < LATENCY; i++) pr_q[i] <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            stall_q <= STALL_RST;
            ovf_q   <= 1'b0;
        end else begin
            pv_q[0] <= pop;
            pr_q[0] <= '{data: head.rw ? head.data : rd_data, id: head.id};
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pr_q[i] <= pr_q[i-1];
            end
            ready_q <= pv_q[LATENCY-1];
            if (pv_q[LATENCY-1]) out_q <= pr_q[LATENCY-1];
            stall_q <= (cnt_d >= STALL_AT) || (state_d != RUN);
            if (valid_in && !push) ovf_q <= 1'b1;
        end
    end

    assign data_out     = out_q.data;
    assign id_out       = out_q.id;
    assign ready_out    = ready_q;
    assign stall_out    = stall_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_dmem_request_engine.sv
// Scoreboard bench for dmem_request_engine (default build).
// Queue/array reference model; monitor checks on the falling edge.
module tb_dmem_request_engine;

    localparam int LAT = 2;
    localparam int DEPTH = 4;
    localparam int AW = 10;

    typedef struct {
        int          idx;
        logic [31:0] d;
        bit          rw;
        logic [3:0]  id;
    } mreq_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  id;
        bit          known;
        int          cyc;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] addr_in = 0;
    logic [31:0] data_in = 0;
    logic        rw_in = 0;
    logic [3:0]  id_in = 0;
    logic        valid_in = 0;
    logic [31:0] data_out;
    logic [3:0]  id_out;
    logic        ready_out;
    logic        stall_out;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    mreq_t       mq[$];
    exp_t        eq[$];
    logic [31:0] mem [int];
    bit          m_stall = 0;
    bit          m_ovf = 0;
    exp_t        me;

    dmem_request_engine #(
        .REQ_DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .data_in(data_in),
        .rw_in(rw_in), .id_in(id_in), .valid_in(valid_in),
        .data_out(data_out), .id_out(id_out),
        .ready_out(ready_out), .stall_out(stall_out),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkaddr(int idx);
        logic [31:0] r;
        r = $urandom();
        r[AW+1:2] = idx[AW-1:0];
        return r;
    endfunction

    task automatic model_step(bit v, bit w, logic [31:0] a,
                              logic [31:0] d, logic [3:0] id);
        mreq_t r;
        exp_t  e;
        if (mq.size() > 0) begin
            r = mq.pop_front();
            e.id = r.id;
            e.cyc = edge_n + LAT;
            e.known = 1;
            if (r.rw) begin
                mem[r.idx] = r.d;
                e.d = r.d;
            end else if (mem.exists(r.idx)) begin
                e.d = mem[r.idx];
            end else begin
                e.d = 'x;
                e.known = 0;
            end
            eq.push_back(e);
        end
        if (v) begin
            if (mq.size() < DEPTH) begin
                r.idx = int'(a[AW+1:2]);
                r.d = d;
                r.rw = w;
                r.id = id;
                mq.push_back(r);
            end else begin
                m_ovf = 1;
            end
        end
        m_stall = (mq.size() >= DEPTH - 1);
    endtask

    task automatic drive(bit v, bit w, logic [31:0] a,
                         logic [31:0] d, logic [3:0] id);
        valid_in = v;
        rw_in = w;
        addr_in = a;
        data_in = d;
        id_in = id;
        @(posedge clk);
        edge_n++;
        if (rst) model_step(v, w, a, d, id);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("stall", 32'(stall_out), 32'(m_stall));
            chk("overflow", 32'(overflow_err), 32'(m_ovf));
            if (eq.size() > 0 && eq[0].cyc == edge_n) begin
                me = eq.pop_front();
                chk("ready", 32'(ready_out), 32'd1);
                chk("resp_id", 32'(id_out), 32'(me.id));
                if (me.known) chk("resp_data", data_out, me.d);
            end else begin
                chk("no_ready", 32'(ready_out), 32'd0);
            end
        end
    end

    initial begin
        int sid;
        #2 rst = 0;
        #1;
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_id", 32'(id_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        idle(2);
        #2 rst = 1;

        drive(1, 1, 32'h10, 32'hDEADBEEF, 4'd3);
        drive(1, 0, 32'h10, 32'h0, 4'd4);
        idle(6);

        for (int i = 0; i < 8; i++)
            drive(1, 1, mkaddr(i), $urandom(), 4'(i));
        idle(4);

        for (int i = 0; i < 8; i++) begin
            while (stall_out) drive(0, 0, 0, 0, 0);
            drive(1, 0, mkaddr(i), 0, 4'(i));
        end
        idle(5);

        for (int i = 0; i < 6; i++)
            drive(1, 0, mkaddr(i), 0, 4'(i + 8));
        idle(5);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(9) < 7 && !stall_out)
                drive(1, 1'($urandom_range(1)), mkaddr($urandom_range(7)),
                      $urandom(), 4'($urandom_range(15)));
            else
                drive(0, 0, 0, 0, 0);
        end
        idle(5);

        sid = 5;
        drive(1, 1, mkaddr(sid), 32'hCAFE0005, 4'd1);
        idle(5);
        drive(1, 0, mkaddr(1), 0, 4'd5);
        drive(1, 1, mkaddr(2), 32'h12345678, 4'd6);
        drive(1, 0, mkaddr(3), 0, 4'd7);
        #2 rst = 0;
        #1;
        chk("mid_rst_ready", 32'(ready_out), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_id", 32'(id_out), 32'd0);
        mq.delete();
        eq.delete();
        m_stall = 0;
        m_ovf = 0;
        idle(2);
        #2 rst = 1;
        idle(6);
        drive(1, 0, mkaddr(sid), 0, 4'd9);
        idle(6);

        chk("drained", 32'(eq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
